vector_pack: RTL

- Upstream neighbour of the vector rearrange stage.
- Gathers a narrow element stream, BEAT_ELEMS elements per beat (e.g. from SRAM read or DMA), into full VEC_ELEMS-element vectors.
- Presents each vector with valid/ready to the rearrange stage.
- Supports early vector termination with zero padding.
- Decouples producer and consumer with one assembly buffer plus one output holding register.

---
 rtl/vector_pack.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vector_pack.sv
// -----------------------------------------------------------------------------
// vector_pack
//
// Gathers a narrow element stream (BEAT_ELEMS elements per beat) into full
// VEC_ELEMS-element vectors for the downstream rearrange stage. A vector is
// closed either when its last beat slot is written or early by in_last. An
// early-closed vector is zero padded above out_count.
//
// One assembly buffer collects beats. One output holding register presents the
// finished vector. If a vector closes while the output register is still
// occupied, the closed vector stays in the assembly buffer (HOLD) and input is
// stalled until the output register drains.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   in_data    beat elements, index 0 is the lowest vector position
//   in_valid   beat valid
//   in_last    final beat of the current vector (forces close)
//   in_ready   beat accepted when in_valid && in_ready
//   out_data   assembled vector
//   out_count  number of valid (non-pad) elements, BEAT_ELEMS..VEC_ELEMS
//   out_last   vector was closed by in_last
//   out_valid  vector valid
//   out_ready  consumer accepts when out_valid && out_ready
//
// State table
//   state   | meaning
//   ST_FILL | assembly buffer accepting beats, in_ready = 1
//   ST_HOLD | closed vector parked in buffer, waiting for output slot
// -----------------------------------------------------------------------------
module vector_pack #(
    parameter int DATA_W     = 16,
    parameter int VEC_ELEMS  = 16,
    parameter int BEAT_ELEMS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            in_data [0:BEAT_ELEMS-1],
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data [0:VEC_ELEMS-1],
    output logic [$clog2(VEC_ELEMS):0]   out_count,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int NBEATS = VEC_ELEMS / BEAT_ELEMS;
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CNT_W  = $clog2(VEC_ELEMS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    generate
        if ((VEC_ELEMS % BEAT_ELEMS) != 0) begin : g_bad_ratio
            $error("vector_pack: BEAT_ELEMS must divide VEC_ELEMS exactly");
        end
    endgenerate

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               state_q;
    logic [DATA_W-1:0]    buf_q      [0:VEC_ELEMS-1];
    logic [IDX_W-1:0]     beat_idx_q;
    logic [CNT_W-1:0]     hold_count_q;
    logic                 hold_last_q;
    logic [DATA_W-1:0]    out_data_q [0:VEC_ELEMS-1];
    logic [CNT_W-1:0]     out_count_q;
    logic                 out_last_q;
    logic                 out_valid_q;

    logic [DATA_W-1:0]    merged_d   [0:VEC_ELEMS-1];
    logic [CNT_W-1:0]     close_count_d;
    logic                 in_fire;
    logic                 out_fire;
    logic                 closing;
    logic                 slot_free;

    assign in_ready  = (state_q == ST_FILL);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign closing   = in_fire && ((beat_idx_q == LAST_IDX) || in_last);
    // Output register is usable this cycle if empty or being drained right now.
    assign slot_free = !out_valid_q || out_ready;

    assign close_count_d = CNT_W'((int'(beat_idx_q) + 1) * BEAT_ELEMS);

    // Buffer contents with the incoming beat overlaid on its slot.
    always_comb begin
        for (int i = 0; i < VEC_ELEMS; i++) begin
            merged_d[i] = buf_q[i];
        end
        for (int b = 0; b < NBEATS; b++) begin
            if (beat_idx_q == IDX_W'(b)) begin
                for (int e = 0; e < BEAT_ELEMS; e++) begin
                    merged_d[b*BEAT_ELEMS + e] = in_data[e];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            buf_q        <= '{default: '0};
            beat_idx_q   <= '0;
            hold_count_q <= '0;
            hold_last_q  <= 1'b0;
            out_data_q   <= '{default: '0};
            out_count_q  <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                    if (in_fire) begin
                        if (!closing) begin
                            buf_q      <= merged_d;
                            beat_idx_q <= beat_idx_q + 1'b1;
                        end else if (slot_free) begin
                            // Direct load; overrides the drain above so a
                            // simultaneous drain leaves no bubble.
                            out_data_q  <= merged_d;
                            out_count_q <= close_count_d;
                            out_last_q  <= in_last;
                            out_valid_q <= 1'b1;
                            buf_q       <= '{default: '0};
                            beat_idx_q  <= '0;
                        end else begin
                            buf_q        <= merged_d;
                            hold_count_q <= close_count_d;
                            hold_last_q  <= in_last;
                            state_q      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_fire) begin
                        // out_valid_q stays set: the parked vector replaces
                        // the one being drained.
                        out_data_q  <= buf_q;
                        out_count_q <= hold_count_q;
                        out_last_q  <= hold_last_q;
                        buf_q       <= '{default: '0};
                        beat_idx_q  <= '0;
                        state_q     <= ST_FILL;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule
